// File: rtl/fp_normalize_round.sv
// Vector FP add back end: turns a raw aligned significand sum plus guard/round/sticky into a
// packed IEEE-754 single per lane. Stage A: carry detect + LZC. Stage B: shift, RNE, pack.
module fp_normalize_round #(
    parameter int unsigned LANES = 16,
    parameter int unsigned THREAD_IDX_W = 2,
    parameter int unsigned PIPE_SEL_W = 2,
    parameter logic [PIPE_SEL_W-1:0] PIPE_MEM = PIPE_SEL_W'(1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_rollback_en,
    input  logic [THREAD_IDX_W-1:0] wb_rollback_thread_idx,
    input  logic [PIPE_SEL_W-1:0]   wb_rollback_pipeline,
    input  logic                    in_valid,
    input  logic [THREAD_IDX_W-1:0] in_thread_idx,
    input  logic [LANES-1:0]        in_mask,
    input  logic [LANES-1:0][24:0]  in_sum,
    input  logic [LANES-1:0]        in_guard,
    input  logic [LANES-1:0]        in_round,
    input  logic [LANES-1:0]        in_sticky,
    input  logic [LANES-1:0][7:0]   in_exponent,
    input  logic [LANES-1:0]        in_sign,
    input  logic [LANES-1:0]        in_logical_subtract,
    input  logic [LANES-1:0]        in_is_inf,
    input  logic [LANES-1:0]        in_is_nan,
    output logic                    out_valid,
    output logic [THREAD_IDX_W-1:0] out_thread_idx,
    output logic [LANES-1:0]        out_mask,
    output logic [LANES-1:0][31:0]  out_result
);

    // Leading zeros of a 26-bit value; returns 26 for an all-zero input.
    function automatic logic [4:0] lzc26(input logic [25:0] v);
        logic [4:0] n;
        n = 5'd26;
        for (int k = 0; k < 26; k++) begin
            if (v[k]) n = 5'(25 - k);
        end
        return n;
    endfunction

    logic                    rolled_back;
    logic                    a_valid_q;
    logic [THREAD_IDX_W-1:0] a_thread_q;
    logic [LANES-1:0]        a_mask_q;
    logic [LANES-1:0][31:0]  result_b;

    assign rolled_back = wb_rollback_en && (wb_rollback_thread_idx == in_thread_idx)
                         && (wb_rollback_pipeline == PIPE_MEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_q <= 1'b0;
        end else begin
            a_valid_q <= in_valid && !rolled_back;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            a_thread_q <= in_thread_idx;
            a_mask_q   <= in_mask;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [25:0] ext_d;
        logic [25:0] ext_q;
        logic [4:0]  lz_d;
        logic [4:0]  lz_q;
        logic        sticky_d;
        logic        sticky_q;
        logic [9:0]  exp_d;
        logic [9:0]  exp_q;
        logic        carry_q;
        logic        sign_q;
        logic        lsub_q;
        logic        inf_q;
        logic        nan_q;

        // A carry-out is pre-normalized by one right shift, so it always enters stage B with lz 0.
        always_comb begin
            ext_d    = '0;
            lz_d     = '0;
            sticky_d = 1'b0;
            exp_d    = {2'b00, in_exponent[i]};
            if (in_sum[i][24]) begin
                ext_d    = {in_sum[i], in_guard[i]};
                sticky_d = in_round[i] | in_sticky[i];
                exp_d    = {2'b00, in_exponent[i]} + 10'd1;
            end else begin
                ext_d    = {in_sum[i][23:0], in_guard[i], in_round[i]};
                lz_d     = lzc26(ext_d);
                sticky_d = in_sticky[i];
            end
        end

        always_ff @(posedge clk) begin
            if (in_valid) begin
                ext_q    <= ext_d;
                lz_q     <= lz_d;
                sticky_q <= sticky_d;
                exp_q    <= exp_d;
                carry_q  <= in_sum[i][24];
                sign_q   <= in_sign[i];
                lsub_q   <= in_logical_subtract[i];
                inf_q    <= in_is_inf[i];
                nan_q    <= in_is_nan[i];
            end
        end

        logic [24:0]        shifted;
        logic [22:0]        mant;
        logic               guard_b;
        logic               round_b;
        logic               round_up;
        logic [23:0]        mant_r;
        logic signed [9:0]  exp_b;
        logic [31:0]        res;

        // The hidden bit drops off the top of the shifted value; exponent is kept signed so that
        // large shifts on small exponents land below zero and flush.
        always_comb begin
            shifted  = 25'(ext_q << lz_q);
            mant     = shifted[24:2];
            guard_b  = shifted[1];
            round_b  = shifted[0];
            round_up = guard_b & (round_b | sticky_q | mant[0]);
            mant_r   = {1'b0, mant} + {23'd0, round_up};
            exp_b    = $signed(exp_q - {5'd0, lz_q} + {9'd0, mant_r[23]});
            if (nan_q) begin
                res = 32'h7FC0_0000;
            end else if (inf_q) begin
                res = {sign_q, 8'hFF, 23'd0};
            end else if ((ext_q == '0) && !carry_q && !sticky_q) begin
                res = lsub_q ? 32'h0 : {sign_q, 31'd0};
            end else if (exp_b >= 10'sd255) begin
                res = {sign_q, 8'hFF, 23'd0};
            end else if (exp_b <= 10'sd0) begin
                res = {sign_q, 31'd0};
            end else begin
                res = {sign_q, exp_b[7:0], mant_r[22:0]};
            end
        end

        assign result_b[i] = res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_thread_idx <= '0;
            out_mask       <= '0;
            out_result     <= '0;
        end else begin
            out_valid <= a_valid_q;
            if (a_valid_q) begin
                out_thread_idx <= a_thread_q;
                out_mask       <= a_mask_q;
                out_result     <= result_b;
            end
        end
    end

endmodule
